exe_ctrl_buffer: RTL and testbench

- Sits directly downstream of an execution pipe's writeback stage.
- Captures each completed instruction's control packet (the ctrl packet sent toward the active list) into a small in-order FIFO.
- Drains the FIFO into a shared active-list completion write port using a valid/ready handshake. This decouples non-stallable execution lanes from arbitration on that port.
- Drives a throttle hint back to the issue logic and records any overflow.

---
 rtl/exe_ctrl_buffer_if.sv | 20 ++
 rtl/exe_ctrl_buffer.sv | 87 ++++++++
 tb/tb_exe_ctrl_buffer.sv | 362 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/exe_ctrl_buffer_if.sv
// exe_ctrl_buffer_if: writeback-side capture and active-list drain handshake of exe_ctrl_buffer.
interface exe_ctrl_buffer_if #(
    parameter int unsigned CTRL_W = 64
);
    logic              ctrlValid_i;
    logic [CTRL_W-1:0] ctrlPacket_i;
    logic              ctrlValid_o;
    logic [CTRL_W-1:0] ctrlPacket_o;
    logic              ctrlReady_i;

    modport slave (
        input  ctrlValid_i, ctrlPacket_i, ctrlReady_i,
        output ctrlValid_o, ctrlPacket_o
    );

    modport master (
        output ctrlValid_i, ctrlPacket_i, ctrlReady_i,
        input  ctrlValid_o, ctrlPacket_o
    );
endinterface

// File: rtl/exe_ctrl_buffer.sv
// exe_ctrl_buffer: in-order FIFO between an execution pipe's writeback and the active-list completion port.
// Optional zero-latency empty-buffer bypass is enabled by defining CTRL_BUF_BYPASS_EN.
module exe_ctrl_buffer #(
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned CTRL_W   = 64,
    parameter int unsigned AFULL_TH = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   recoverFlag_i,
    input  logic                   exceptionFlag_i,
    exe_ctrl_buffer_if.slave       bus,
    output logic                   almostFull_o,
    output logic [$clog2(DEPTH):0] count_o,
    output logic                   overflow_o
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_C = DEPTH[AW:0];

    logic [CTRL_W-1:0] mem_q [DEPTH];
    logic [CTRL_W-1:0] head_q, head_d;
    logic [AW:0]       wr_q, wr_d, rd_q, rd_d;
    logic [AW:0]       count, count_d;
    logic              ovf_q, ovf_d;
    logic              flush, full, push, pop;

    assign flush = recoverFlag_i | exceptionFlag_i;
    assign count = wr_q - rd_q;
    assign full  = (count == DEPTH_C);

`ifdef CTRL_BUF_BYPASS_EN
    logic bypass;
    assign bypass           = (count == '0) & bus.ctrlValid_i & ~flush;
    assign bus.ctrlValid_o  = (count != '0) | bypass;
    assign bus.ctrlPacket_o = bypass ? bus.ctrlPacket_i : head_q;
`else
    assign bus.ctrlValid_o  = (count != '0);
    assign bus.ctrlPacket_o = head_q;
`endif

    assign pop          = bus.ctrlValid_o & bus.ctrlReady_i;
    assign count_o      = count;
    assign almostFull_o = (32'(count) >= AFULL_TH);
    assign overflow_o   = ovf_q;

    // A bypassed-and-consumed packet pushes and pops together, so occupancy stays zero.
    always_comb begin
        push    = bus.ctrlValid_i & (~full | pop) & ~flush;
        ovf_d   = ovf_q | (bus.ctrlValid_i & full & ~pop & ~flush);
        wr_d    = wr_q + {{AW{1'b0}}, push};
        rd_d    = rd_q + {{AW{1'b0}}, pop};
        if (flush) begin
            wr_d = '0;
            rd_d = '0;
        end
        count_d = wr_d - rd_d;
        head_d  = head_q;
        if (count_d != '0) begin
            // New head may be the slot written this very edge, not yet visible in mem_q.
            if (push && (wr_q[AW-1:0] == rd_d[AW-1:0])) begin
                head_d = bus.ctrlPacket_i;
            end else begin
                head_d = mem_q[rd_d[AW-1:0]];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_q[AW-1:0]] <= bus.ctrlPacket_i;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_q   <= '0;
            rd_q   <= '0;
            head_q <= '0;
            ovf_q  <= 1'b0;
        end else begin
            wr_q   <= wr_d;
            rd_q   <= rd_d;
            head_q <= head_d;
            ovf_q  <= ovf_d;
        end
    end
endmodule

// File: tb/tb_exe_ctrl_buffer.sv
// tb_exe_ctrl_buffer: directed and randomized checks of exe_ctrl_buffer against a queue-based model.
module tb_exe_ctrl_buffer;
    localparam int unsigned DEPTH    = 4;
    localparam int unsigned CTRL_W   = 64;
    localparam int unsigned AFULL_TH = 2;
`ifdef CTRL_BUF_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       recoverFlag_i = 1'b0;
    logic       exceptionFlag_i = 1'b0;
    logic       almostFull_o;
    logic [2:0] count_o;
    logic       overflow_o;
    int unsigned errors = 0;
    int unsigned checks = 0;

    exe_ctrl_buffer_if #(.CTRL_W(CTRL_W)) bus ();

    exe_ctrl_buffer #(.DEPTH(DEPTH), .CTRL_W(CTRL_W), .AFULL_TH(AFULL_TH)) dut (
        .clk(clk), .reset(reset), .recoverFlag_i(recoverFlag_i), .exceptionFlag_i(exceptionFlag_i),
        .bus(bus), .almostFull_o(almostFull_o), .count_o(count_o), .overflow_o(overflow_o)
    );

    always #5 clk = ~clk;

    // Reference model: the buffer contents as a plain queue plus a sticky overflow flag.
    logic [CTRL_W-1:0] mq[$];
    bit                movf;

    function automatic bit m_bypass();
        return BYP && (mq.size() == 0) && (bus.ctrlValid_i === 1'b1) && !(recoverFlag_i || exceptionFlag_i);
    endfunction

    function automatic bit m_valid();
        return (mq.size() != 0) || m_bypass();
    endfunction

    function automatic logic [CTRL_W-1:0] m_head();
        if (m_bypass()) return bus.ctrlPacket_i;
        return mq[0];
    endfunction

    task automatic set_in(input bit v, input logic [CTRL_W-1:0] p, input bit r, input bit rec, input bit exc);
        bus.ctrlValid_i  = v;
        bus.ctrlPacket_i = p;
        bus.ctrlReady_i  = r;
        recoverFlag_i    = rec;
        exceptionFlag_i  = exc;
    endtask

    task automatic tick();
        bit fl, pp;
        fl = recoverFlag_i || exceptionFlag_i;
        pp = m_valid() && bus.ctrlReady_i;
        if (fl) begin
            mq.delete();
        end else if (!(m_bypass() && pp)) begin
            if (pp) void'(mq.pop_front());
            if (bus.ctrlValid_i) begin
                if (mq.size() < DEPTH) mq.push_back(bus.ctrlPacket_i);
                else movf = 1'b1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        set_in(0, '0, 0, 0, 0);
        reset = 1'b0;
        mq.delete();
        movf = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    task automatic test_reset();
        set_in(0, '0, 0, 0, 0);
        reset = 1'b0;
        mq.delete();
        movf = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if ({bus.ctrlValid_o, count_o, almostFull_o, overflow_o, bus.ctrlPacket_o} !== {1'b0, 3'd0, 1'b0, 1'b0, 64'd0}) begin
                errors++;
                $display("FAIL reset_hold: valid=%b count=%0d afull=%b ovf=%b pkt=%h want all zero",
                         bus.ctrlValid_o, count_o, almostFull_o, overflow_o, bus.ctrlPacket_o);
            end
        end
        reset = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if ({bus.ctrlValid_o, count_o, almostFull_o, overflow_o} !== {1'b0, 3'd0, 1'b0, 1'b0}) begin
                errors++;
                $display("FAIL reset_idle: valid=%b count=%0d afull=%b ovf=%b want 0/0/0/0",
                         bus.ctrlValid_o, count_o, almostFull_o, overflow_o);
            end
        end
    endtask

    task automatic test_in_order();
        logic [CTRL_W-1:0] pk[3];
        pk = '{64'h11, 64'h22, 64'h33};
        do_reset();
        for (int i = 0; i < 3; i++) begin
            set_in(1, pk[i], 0, 0, 0);
            tick();
            checks++;
            if (count_o !== 3'(i + 1) || almostFull_o !== (i + 1 >= AFULL_TH)) begin
                errors++;
                $display("FAIL fill_count: count=%0d afull=%b want %0d/%b", count_o, almostFull_o, i + 1, i + 1 >= AFULL_TH);
            end
            checks++;
            if (bus.ctrlValid_o !== 1'b1 || bus.ctrlPacket_o !== pk[0]) begin
                errors++;
                $display("FAIL fill_head: valid=%b pkt=%h want 1/%h", bus.ctrlValid_o, bus.ctrlPacket_o, pk[0]);
            end
        end
        set_in(0, '0, 1, 0, 0);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (bus.ctrlValid_o !== 1'b1 || bus.ctrlPacket_o !== pk[i]) begin
                errors++;
                $display("FAIL drain_order: valid=%b pkt=%h want 1/%h", bus.ctrlValid_o, bus.ctrlPacket_o, pk[i]);
            end
            tick();
            checks++;
            if (count_o !== 3'(2 - i) || almostFull_o !== (2 - i >= AFULL_TH)) begin
                errors++;
                $display("FAIL drain_count: count=%0d afull=%b want %0d/%b", count_o, almostFull_o, 2 - i, 2 - i >= AFULL_TH);
            end
        end
        checks++;
        if (bus.ctrlValid_o !== 1'b0) begin
            errors++;
            $display("FAIL drain_empty: valid=%b want 0", bus.ctrlValid_o);
        end
    endtask

    task automatic test_overflow();
        do_reset();
        for (int i = 0; i < 5; i++) begin
            set_in(1, 64'hA0 + 64'(i), 0, 0, 0);
            tick();
            checks++;
            if (count_o !== 3'((i < 4) ? i + 1 : 4) || overflow_o !== (i == 4)) begin
                errors++;
                $display("FAIL ovf_fill: count=%0d ovf=%b want %0d/%b", count_o, overflow_o, (i < 4) ? i + 1 : 4, i == 4);
            end
        end
        set_in(0, '0, 1, 0, 0);
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (bus.ctrlValid_o !== (i < 4) || (i < 4 && bus.ctrlPacket_o !== 64'hA0 + 64'(i))) begin
                errors++;
                $display("FAIL ovf_drain: valid=%b pkt=%h want %b/%h", bus.ctrlValid_o, bus.ctrlPacket_o, i < 4, 64'hA0 + 64'(i));
            end
            tick();
        end
        checks++;
        if (overflow_o !== 1'b1) begin
            errors++;
            $display("FAIL ovf_sticky: ovf=%b want 1", overflow_o);
        end
    endtask

    task automatic test_full_pushpop();
        logic [CTRL_W-1:0] exp[4];
        exp = '{64'hB1, 64'hB2, 64'hB3, 64'hAA};
        do_reset();
        for (int i = 0; i < 4; i++) begin
            set_in(1, 64'hB0 + 64'(i), 0, 0, 0);
            tick();
        end
        set_in(1, 64'hAA, 1, 0, 0);
        checks++;
        if (bus.ctrlPacket_o !== 64'hB0) begin
            errors++;
            $display("FAIL full_head: pkt=%h want b0", bus.ctrlPacket_o);
        end
        tick();
        checks++;
        if (count_o !== 3'd4 || overflow_o !== 1'b0) begin
            errors++;
            $display("FAIL full_pushpop: count=%0d ovf=%b want 4/0", count_o, overflow_o);
        end
        set_in(0, '0, 1, 0, 0);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (bus.ctrlValid_o !== 1'b1 || bus.ctrlPacket_o !== exp[i]) begin
                errors++;
                $display("FAIL full_order: valid=%b pkt=%h want 1/%h", bus.ctrlValid_o, bus.ctrlPacket_o, exp[i]);
            end
            tick();
        end
    endtask

    task automatic test_flush();
        for (int w = 0; w < 2; w++) begin
            do_reset();
            for (int i = 0; i < 3; i++) begin
                set_in(1, 64'hC0 + 64'(i), 0, 0, 0);
                tick();
            end
            set_in(1, 64'h55, 0, w == 0, w == 1);
            tick();
            checks++;
            if (count_o !== 3'd0 || bus.ctrlValid_o !== 1'b0 || almostFull_o !== 1'b0) begin
                errors++;
                $display("FAIL flush_%0d: count=%0d valid=%b afull=%b want 0/0/0", w, count_o, bus.ctrlValid_o, almostFull_o);
            end
            set_in(0, '0, 1, 0, 0);
            for (int i = 0; i < 3; i++) begin
                tick();
                checks++;
                if (bus.ctrlValid_o !== 1'b0) begin
                    errors++;
                    $display("FAIL flush_ghost_%0d: valid=%b pkt=%h want 0", w, bus.ctrlValid_o, bus.ctrlPacket_o);
                end
            end
        end
        // Overflow survives a flush; a flush with a full buffer does not create one.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            set_in(1, 64'hD0 + 64'(i), 0, 0, 0);
            tick();
        end
        set_in(1, 64'hD9, 0, 1, 0);
        tick();
        checks++;
        if (overflow_o !== 1'b0 || count_o !== 3'd0) begin
            errors++;
            $display("FAIL flush_full: ovf=%b count=%0d want 0/0", overflow_o, count_o);
        end
        for (int i = 0; i < 5; i++) begin
            set_in(1, 64'hE0 + 64'(i), 0, 0, 0);
            tick();
        end
        set_in(0, '0, 1, 0, 1);
        tick();
        checks++;
        if (overflow_o !== 1'b1 || count_o !== 3'd0) begin
            errors++;
            $display("FAIL flush_keep_ovf: ovf=%b count=%0d want 1/0", overflow_o, count_o);
        end
    endtask

    task automatic test_bypass();
        do_reset();
        set_in(1, 64'h77, 1, 0, 0);
        #1;
`ifdef CTRL_BUF_BYPASS_EN
        checks++;
        if (bus.ctrlValid_o !== 1'b1 || bus.ctrlPacket_o !== 64'h77) begin
            errors++;
            $display("FAIL bypass_comb: valid=%b pkt=%h want 1/77", bus.ctrlValid_o, bus.ctrlPacket_o);
        end
        tick();
        checks++;
        if (count_o !== 3'd0 || bus.ctrlValid_o !== 1'b1) begin
            errors++;
            $display("FAIL bypass_consumed: count=%0d valid=%b want 0/1(input still held)", count_o, bus.ctrlValid_o);
        end
        set_in(0, '0, 1, 0, 0);
        #1;
        checks++;
        if (bus.ctrlValid_o !== 1'b0) begin
            errors++;
            $display("FAIL bypass_after: valid=%b want 0", bus.ctrlValid_o);
        end
`else
        checks++;
        if (bus.ctrlValid_o !== 1'b0) begin
            errors++;
            $display("FAIL nobypass_comb: valid=%b want 0", bus.ctrlValid_o);
        end
        tick();
        checks++;
        if (count_o !== 3'd1 || bus.ctrlValid_o !== 1'b1 || bus.ctrlPacket_o !== 64'h77) begin
            errors++;
            $display("FAIL nobypass_latency: count=%0d valid=%b pkt=%h want 1/1/77", count_o, bus.ctrlValid_o, bus.ctrlPacket_o);
        end
        set_in(0, '0, 1, 0, 0);
        tick();
        checks++;
        if (count_o !== 3'd0) begin
            errors++;
            $display("FAIL nobypass_drain: count=%0d want 0", count_o);
        end
`endif
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int occ = 1; occ <= int'(DEPTH); occ++) begin
            for (int i = 0; i < occ; i++) begin
                set_in(1, {$urandom, $urandom}, 0, 0, 0);
                tick();
            end
            for (int i = 0; i < 8; i++) begin
                set_in(1, {$urandom, $urandom}, 1, 0, 0);
                #1;
                checks++;
                if (bus.ctrlValid_o !== 1'b1 || bus.ctrlPacket_o !== m_head()) begin
                    errors++;
                    $display("FAIL b2b_head: occ=%0d pkt=%h want %h", occ, bus.ctrlPacket_o, m_head());
                end
                tick();
                checks++;
                if (count_o !== 3'(occ) || overflow_o !== 1'b0) begin
                    errors++;
                    $display("FAIL b2b_count: count=%0d ovf=%b want %0d/0", count_o, overflow_o, occ);
                end
            end
            set_in(0, '0, 0, 1, 0);
            tick();
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 400; i++) begin
            set_in($urandom_range(0, 9) < 7, {$urandom, $urandom}, $urandom_range(0, 1) == 1,
                   $urandom_range(0, 29) == 0, $urandom_range(0, 29) == 0);
            #1;
            checks++;
            if (bus.ctrlValid_o !== m_valid() || (m_valid() && bus.ctrlPacket_o !== m_head())) begin
                errors++;
                $display("FAIL rand_out @%0d: valid=%b pkt=%h want %b/%h", i, bus.ctrlValid_o, bus.ctrlPacket_o, m_valid(), m_head());
            end
            tick();
            checks++;
            if (count_o !== 3'(mq.size()) || almostFull_o !== (mq.size() >= AFULL_TH) || overflow_o !== movf) begin
                errors++;
                $display("FAIL rand_state @%0d: count=%0d afull=%b ovf=%b want %0d/%b/%b",
                         i, count_o, almostFull_o, overflow_o, mq.size(), mq.size() >= AFULL_TH, movf);
            end
        end
    endtask

    initial begin
        test_reset();
        test_in_order();
        test_overflow();
        test_full_pushpop();
        test_flush();
        test_bypass();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
